pll_lock_reset_sequencer: RTL and testbench
===========================================

Name: pll_lock_reset_sequencer

Overview:
- Consumer end of the PLL `lock` interface. Runs on the free-running 27 MHz crystal clock.
- Drives the PLL's active-high RESET input.
- Watches the PLL's asynchronous `lock` output and releases the system reset only after lock has been stable for a programmable time.
- Retries the PLL when lock fails to arrive, and re-asserts system reset on lock loss.
- `sys_resetn` feeds the per-domain reset synchronizers in the 126 MHz pixel/TMDS domain.

Parameters:
- SYNC_STAGES, 2, flops in the `pll_lock` synchronizer (minimum 2).
- PLL_RST_CYCLES, 27, cycles `pll_reset` is held high per reset attempt (1 us at 27 MHz).
- STABLE_CYCLES, 2700, consecutive synchronized-lock-high cycles required before release (100 us).
- LOCK_TIMEOUT, 270000, cycles to wait for lock before re-resetting the PLL (10 ms).
- CNT_W, 20, width of the shared down/up cycle counter; must hold max(PLL_RST_CYCLES, STABLE_CYCLES, LOCK_TIMEOUT).

Ports:
- clkin  input  1  27 MHz free-running reference clock
- resetn  input  1  asynchronous active-low reset
- pll_lock  input  1  PLL lock, asynchronous to clkin
- pll_reset  output  1  active-high reset to PLL
- sys_resetn  output  1  active-low system reset request, asynchronous-assert safe for downstream synchronizers
- locked_ok  output  1  high while in RUN
- state_dbg  output  2  current state encoding
- retry_count  output  4  PLL reset attempts due to timeout, saturating at 15

Behaviour:
- Reset (resetn=0), asynchronous:
  - state=PLL_RST, counter=0, synchronizer flops=0.
  - pll_reset=1, sys_resetn=0, locked_ok=0, retry_count=0.
- Synchronizer: pll_lock passes through SYNC_STAGES flops to give lock_s. A lock edge is visible to the FSM SYNC_STAGES cycles later.
- State encoding: PLL_RST=0, WAIT_LOCK=1, STABILIZE=2, RUN=3.
- All outputs are registered and decoded from the current state:
  - pll_reset=(state==PLL_RST).
  - sys_resetn=(state==RUN).
  - locked_ok=(state==RUN).
- PLL_RST:
  - Counter increments each cycle.
  - When counter==PLL_RST_CYCLES-1: go to WAIT_LOCK and clear counter.
  - pll_reset is therefore high exactly PLL_RST_CYCLES cycles after resetn release.
  - lock_s is ignored in this state.
- WAIT_LOCK:
  - If lock_s=1: go to STABILIZE, counter=0.
  - Else if counter==LOCK_TIMEOUT-1: go to PLL_RST, counter=0, retry_count+1 (saturating at 15).
  - Else: counter+1.
  - If lock_s rises in the same cycle as the timeout is reached, lock wins and the FSM goes to STABILIZE.
- STABILIZE:
  - If lock_s=0: go to WAIT_LOCK, counter=0. The timeout restarts; a glitching lock never escalates to a PLL reset until it stays low for the full timeout.
  - Else if counter==STABLE_CYCLES-1: go to RUN.
  - Else: counter+1.
- RUN:
  - Holds while lock_s=1.
  - On lock_s=0: go to WAIT_LOCK, counter=0. sys_resetn falls on the next clkin edge (lock loss → sys_resetn low latency = SYNC_STAGES+1 cycles).
  - No PLL reset is issued unless the subsequent wait times out.
- Counter arithmetic: unsigned CNT_W, never wraps. Every state compares and clears before the terminal count.
- retry_count clears only on resetn; it is not cleared by reaching RUN.
- resetn asserted mid-operation: immediate return to the reset values above, regardless of state.

Optional Feature:
- Macro: PLL_LOCK_LOSS_COUNT_EN.
- Defined:
  - Adds output `lock_loss_count`, 8 bits.
  - Increments by 1 on each RUN→WAIT_LOCK transition, saturating at 255.
  - Clears only on resetn.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Bench parameters for all scenarios: SYNC_STAGES=2, PLL_RST_CYCLES=4, STABLE_CYCLES=8, LOCK_TIMEOUT=32.
- Clean start: release resetn with pll_lock=1 held → pll_reset high exactly 4 cycles; sys_resetn rises 4+1+8 cycles (±SYNC_STAGES) after release; retry_count=0.
- Timeout retry: pll_lock=0 forever → pll_reset pulses of 4 cycles every 36 cycles; retry_count counts 1,2,… and holds at 15; sys_resetn stays 0.
- Stabilize glitch: lock high 5 cycles, low 1 cycle, high again → FSM returns to WAIT_LOCK then STABILIZE; sys_resetn rises only after 8 uninterrupted high cycles; no pll_reset pulse.
- Lock loss in RUN: drop pll_lock for 3 cycles → sys_resetn low 3 cycles (SYNC_STAGES+1) after the drop; re-stabilizes after 8 cycles; lock_loss_count=1 when the macro is defined; no pll_reset.
- Reset mid-STABILIZE: assert resetn at counter=5 → pll_reset=1 and sys_resetn=0 asynchronously (same instant); state_dbg=0; retry_count=0.
- Simultaneous lock and timeout: lock_s rises on cycle 31 of WAIT_LOCK → state_dbg=2, no pll_reset, retry_count unchanged.

Source files
------------

// File: rtl/pll_lock_reset_sequencer.sv
// Sequences PLL reset, waits for a stable synchronized lock, then releases sys_resetn; retries on timeout.
// Latency: lock edge reaches the FSM after SYNC_STAGES cycles; outputs are flops updated from next state.
// No backpressure. PLL_LOCK_LOSS_COUNT_EN adds a saturating RUN->WAIT_LOCK event counter output.
module pll_lock_reset_sequencer #(
   parameter int SYNC_STAGES    = 2,
   parameter int PLL_RST_CYCLES = 27,
   parameter int STABLE_CYCLES  = 2700,
   parameter int LOCK_TIMEOUT   = 270000,
   parameter int CNT_W          = 20
) (
   input  logic       clkin,
   input  logic       resetn,
   input  logic       pll_lock,
   output logic       pll_reset,
   output logic       sys_resetn,
   output logic       locked_ok,
   output logic [1:0] state_dbg,
   output logic [3:0] retry_count
`ifdef PLL_LOCK_LOSS_COUNT_EN
   ,
   output logic [7:0] lock_loss_count
`endif
);

   typedef enum logic [1:0] {
      PLL_RST   = 2'd0,
      WAIT_LOCK = 2'd1,
      STABILIZE = 2'd2,
      RUN       = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lock_s;
   state_t                 state_q, state_nxt;
   logic [CNT_W-1:0]       cnt_q, cnt_nxt;
   logic                   retry_inc;

   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) sync_q <= '0;
      else         sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
   end

   assign lock_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      retry_inc = 1'b0;
      case (state_q)
         PLL_RST: begin
            if (cnt_q == RST_LAST) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end
         WAIT_LOCK: begin
            // lock beats a timeout landing on the same cycle
            if (lock_s) begin
               state_nxt = STABILIZE;
               cnt_nxt   = '0;
            end else if (cnt_q == TO_LAST) begin
               state_nxt = PLL_RST;
               cnt_nxt   = '0;
               retry_inc = 1'b1;
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end
         STABILIZE: begin
            if (!lock_s) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = '0;
            end else if (cnt_q == STB_LAST) begin
               state_nxt = RUN;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end
         RUN: begin
            if (!lock_s) begin
               state_nxt = WAIT_LOCK;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = PLL_RST;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs get their own flops so sys_resetn cannot glitch on multi-bit state changes.
   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn) begin
         state_q     <= PLL_RST;
         cnt_q       <= '0;
         pll_reset   <= 1'b1;
         sys_resetn  <= 1'b0;
         locked_ok   <= 1'b0;
         retry_count <= 4'd0;
      end else begin
         state_q    <= state_nxt;
         cnt_q      <= cnt_nxt;
         pll_reset  <= (state_nxt == PLL_RST);
         sys_resetn <= (state_nxt == RUN);
         locked_ok  <= (state_nxt == RUN);
         if (retry_inc && (retry_count != 4'hF))
            retry_count <= retry_count + 4'd1;
      end
   end

   assign state_dbg = state_q;

`ifdef PLL_LOCK_LOSS_COUNT_EN
   always_ff @(posedge clkin or negedge resetn) begin
      if (!resetn)
         lock_loss_count <= 8'd0;
      else if ((state_q == RUN) && (state_nxt == WAIT_LOCK) && (lock_loss_count != 8'hFF))
         lock_loss_count <= lock_loss_count + 8'd1;
   end
`endif

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// Directed bench for pll_lock_reset_sequencer with SYNC_STAGES=2, PLL_RST_CYCLES=4, STABLE_CYCLES=8, LOCK_TIMEOUT=32.
module tb_pll_lock_reset_sequencer;

   logic       clkin = 1'b0;
   logic       resetn;
   logic       pll_lock;
   logic       pll_reset;
   logic       sys_resetn;
   logic       locked_ok;
   logic [1:0] state_dbg;
   logic [3:0] retry_count;
`ifdef PLL_LOCK_LOSS_COUNT_EN
   logic [7:0] lock_loss_count;
`endif

   int n_checks = 0;
   int n_err    = 0;

   always #5 clkin = ~clkin;

   pll_lock_reset_sequencer #(
      .SYNC_STAGES   (2),
      .PLL_RST_CYCLES(4),
      .STABLE_CYCLES (8),
      .LOCK_TIMEOUT  (32),
      .CNT_W         (20)
   ) dut (
      .clkin      (clkin),
      .resetn     (resetn),
      .pll_lock   (pll_lock),
      .pll_reset  (pll_reset),
      .sys_resetn (sys_resetn),
      .locked_ok  (locked_ok),
      .state_dbg  (state_dbg),
      .retry_count(retry_count)
`ifdef PLL_LOCK_LOSS_COUNT_EN
      ,
      .lock_loss_count(lock_loss_count)
`endif
   );

   typedef struct packed {
      logic       rn;
      logic       lk;
      logic       pr;
      logic       sr;
      logic [1:0] st;
      logic [3:0] rc;
   } vec_t;

   vec_t vecs [15];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clkin);
      #1;
   endtask

   task automatic start(input logic lk);
      resetn   = 1'b0;
      pll_lock = lk;
      tick();
      tick();
      resetn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      resetn   = 1'b0;
      pll_lock = 1'b1;

      // clean start: each entry is applied, one edge elapses, then outputs are compared
      vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0};
      vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0};
      vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0};
      vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'd0};
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'd0};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'd0};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'd0};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'd0};
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'd0};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'd0};
      vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'd0};
      vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 4'd0};
      vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 4'd0};
      vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd3, 4'd0};

      for (int i = 0; i < 15; i++) begin
         resetn   = vecs[i].rn;
         pll_lock = vecs[i].lk;
         tick();
         chk($sformatf("clean_pll_reset[%0d]", i), pll_reset, vecs[i].pr);
         chk($sformatf("clean_sys_resetn[%0d]", i), sys_resetn, vecs[i].sr);
         chk($sformatf("clean_locked_ok[%0d]", i), locked_ok, vecs[i].sr);
         chk($sformatf("clean_state[%0d]", i), state_dbg, vecs[i].st);
         chk($sformatf("clean_retry[%0d]", i), retry_count, vecs[i].rc);
      end

      // lock loss in RUN: lock low for 3 cycles
      pll_lock = 1'b0;
      for (int e = 1; e <= 14; e++) begin
         tick();
         if (e == 3) pll_lock = 1'b1;
         chk($sformatf("loss_state[%0d]", e), state_dbg,
             (e <= 2) ? 3 : (e <= 5) ? 1 : (e <= 13) ? 2 : 3);
         chk($sformatf("loss_sys_resetn[%0d]", e), sys_resetn, (e <= 2 || e == 14) ? 1 : 0);
         chk($sformatf("loss_pll_reset[%0d]", e), pll_reset, 0);
      end
      chk("loss_retry", retry_count, 0);
`ifdef PLL_LOCK_LOSS_COUNT_EN
      chk("loss_count_after_loss", lock_loss_count, 1);
`endif

      // lock_s reaches 1 exactly on the timeout cycle: lock wins
      start(1'b0);
`ifdef PLL_LOCK_LOSS_COUNT_EN
      chk("loss_count_after_reset", lock_loss_count, 0);
`endif
      for (int e = 1; e <= 36; e++) begin
         tick();
         if (e == 33) pll_lock = 1'b1;
         if (e == 35) chk("simul_state_pre", state_dbg, 1);
      end
      chk("simul_state", state_dbg, 2);
      chk("simul_pll_reset", pll_reset, 0);
      chk("simul_retry", retry_count, 0);

      // lock one cycle too late: timeout, then stabilize and reset at counter 5
      start(1'b0);
      for (int e = 1; e <= 46; e++) begin
         tick();
         if (e == 34) pll_lock = 1'b1;
         if (e == 36) begin
            chk("late_state", state_dbg, 0);
            chk("late_pll_reset", pll_reset, 1);
            chk("late_retry", retry_count, 1);
         end
         if (e == 41) chk("late_stab_entry", state_dbg, 2);
      end
      chk("midstab_state_pre", state_dbg, 2);
      chk("midstab_pll_reset_pre", pll_reset, 0);
      resetn = 1'b0;
      #1;
      chk("midstab_pll_reset", pll_reset, 1);
      chk("midstab_sys_resetn", sys_resetn, 0);
      chk("midstab_state", state_dbg, 0);
      chk("midstab_retry", retry_count, 0);
      chk("midstab_locked_ok", locked_ok, 0);
      tick();
      chk("midstab_hold_state", state_dbg, 0);

      // glitch in STABILIZE: restart to WAIT_LOCK, no PLL reset
      start(1'b1);
      for (int e = 1; e <= 20; e++) begin
         tick();
         if (e == 8) pll_lock = 1'b0;
         if (e == 9) pll_lock = 1'b1;
         chk($sformatf("glitch_state[%0d]", e), state_dbg,
             (e < 4) ? 0 : (e == 4) ? 1 : (e <= 10) ? 2 : (e == 11) ? 1 : (e <= 19) ? 2 : 3);
         chk($sformatf("glitch_pll_reset[%0d]", e), pll_reset, (e < 4) ? 1 : 0);
         chk($sformatf("glitch_sys_resetn[%0d]", e), sys_resetn, (e == 20) ? 1 : 0);
      end

      // lock never arrives: 4-cycle pulses every 36 cycles, retry saturates at 15
      start(1'b0);
      for (int k = 1; k <= 36 * 17 + 5; k++) begin
         tick();
         chk($sformatf("to_pll_reset[%0d]", k), pll_reset, ((k % 36) < 4) ? 1 : 0);
         chk($sformatf("to_state[%0d]", k), state_dbg, ((k % 36) < 4) ? 0 : 1);
         chk($sformatf("to_sys_resetn[%0d]", k), sys_resetn, 0);
         chk($sformatf("to_retry[%0d]", k), retry_count, ((k / 36) > 15) ? 15 : (k / 36));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
